// File: rtl/wb_stage.sv
// wb_stage: write-back stage; retires ALU results and waits for load data,
// formatting byte/half/word loads and reporting misaligned or timed-out loads.
module wb_stage #(
    parameter int LOAD_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_rd,
    input  logic [31:0] in_result,
    input  logic        in_isWb,
    input  logic        in_isLd,
    input  logic [1:0]  in_ldSize,
    input  logic        in_ldUnsigned,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        isWb,
    output logic [3:0]  writeaddress,
    output logic [31:0] writeData,
    output logic        pend_valid,
    output logic [3:0]  pend_rd,
    output logic        ld_err,
    output logic [31:0] wb_count
);
    localparam int CW = $clog2(LOAD_TIMEOUT + 1);
    typedef enum logic {IDLE, WAIT_LD} state_t;
    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]  rd_q, rd_d, waddr_q, waddr_d;
    logic [1:0]  off_q, off_d, size_q, size_d;
    logic        uns_q, uns_d, iswb_q, iswb_d, err_q, err_d;
    logic [31:0] wdata_q, wdata_d, wbcnt_q, wbcnt_d;
    logic        xfer, mis, timeout;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] ld_data;

    assign xfer    = in_valid && state_q == IDLE;
    assign mis     = in_ldSize == 2'b11 || (in_ldSize == 2'b01 && in_result[0]) ||
                     (in_ldSize == 2'b10 && in_result[1:0] != 2'b00);
    assign timeout = cnt_q == CW'(LOAD_TIMEOUT - 1);
    assign byte_v  = mem_rdata[{off_q, 3'b000} +: 8];
    assign half_v  = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    assign ld_data = size_q == 2'b00 ? {{24{~uns_q & byte_v[7]}}, byte_v} :
                     size_q == 2'b01 ? {{16{~uns_q & half_v[15]}}, half_v} : mem_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q == IDLE ? ((xfer && in_isLd && !mis) ? WAIT_LD : IDLE)
                                  : ((mem_rvalid || timeout) ? IDLE : WAIT_LD);
    end

    always_comb begin
        iswb_d  = 1'b0;
        err_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        off_d   = off_q;
        size_d  = size_q;
        uns_d   = uns_q;
        if (state_q == IDLE) begin
            if (xfer && in_isLd) begin
                err_d = mis;
                if (!mis) begin
                    rd_d   = in_rd;
                    off_d  = in_result[1:0];
                    size_d = in_ldSize;
                    uns_d  = in_ldUnsigned;
                    cnt_d  = '0;
                end
            end else if (xfer && in_isWb && in_rd != 4'd0) begin
                iswb_d  = 1'b1;
                waddr_d = in_rd;
                wdata_d = in_result;
            end
        end else if (mem_rvalid) begin
            // rvalid wins over a coincident timeout
            iswb_d  = rd_q != 4'd0;
            waddr_d = iswb_d ? rd_q : waddr_q;
            wdata_d = iswb_d ? ld_data : wdata_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
            err_d = timeout;
        end
        wbcnt_d = wbcnt_q + {31'd0, iswb_d};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            rd_q    <= '0;
            off_q   <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            iswb_q  <= 1'b0;
            err_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            wbcnt_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            off_q   <= off_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            iswb_q  <= iswb_d;
            err_q   <= err_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            wbcnt_q <= wbcnt_d;
        end
    end

    assign in_ready     = state_q == IDLE;
    assign pend_valid   = state_q == WAIT_LD;
    assign pend_rd      = rd_q;
    assign isWb         = iswb_q;
    assign writeaddress = waddr_q;
    assign writeData    = wdata_q;
    assign ld_err       = err_q;
    assign wb_count     = wbcnt_q;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed scenarios plus randomized traffic checked against a
// transaction-level model of the write-back stage.
module tb_wb_stage;
    localparam int LT = 16;
    logic        clk = 1'b0, reset = 1'b0;
    logic        in_valid = 1'b0, in_isWb = 1'b0, in_isLd = 1'b0, in_ldUnsigned = 1'b0;
    logic [3:0]  in_rd = '0;
    logic [31:0] in_result = '0, mem_rdata = '0;
    logic [1:0]  in_ldSize = '0;
    logic        mem_rvalid = 1'b0;
    logic        in_ready, isWb, pend_valid, ld_err;
    logic [3:0]  writeaddress, pend_rd;
    logic [31:0] writeData, wb_count;
    int n_chk = 0, n_fail = 0;

    // model state
    bit          m_busy;
    logic [3:0]  m_rd;
    int          m_off, m_size, m_wait;
    bit          m_uns;
    logic        e_wb, e_err;
    logic [3:0]  e_addr;
    logic [31:0] e_data, e_cnt;

    wb_stage #(.LOAD_TIMEOUT(LT)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_result(in_result), .in_isWb(in_isWb), .in_isLd(in_isLd),
        .in_ldSize(in_ldSize), .in_ldUnsigned(in_ldUnsigned), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .isWb(isWb), .writeaddress(writeaddress), .writeData(writeData),
        .pend_valid(pend_valid), .pend_rd(pend_rd), .ld_err(ld_err), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fmt(logic [31:0] w, int off, int size, bit uns);
        int v;
        if (size == 2) return w;
        if (size == 0) begin
            v = int'((w >> (8 * off)) % 256);
            if (!uns && v >= 128) v -= 256;
        end else begin
            v = int'((w >> (8 * off)) % 65536);
            if (!uns && v >= 32768) v -= 65536;
        end
        return 32'(v);
    endfunction

    task automatic model_clear();
        m_busy = 0; m_rd = '0; m_wait = 0; m_off = 0; m_size = 0; m_uns = 0;
        e_wb = 0; e_err = 0; e_addr = '0; e_data = '0; e_cnt = '0;
    endtask

    // advance one clock, predicting the outputs that edge produces
    task automatic tick();
        int a, sz;
        e_wb = 0;
        e_err = 0;
        if (!m_busy) begin
            if (in_valid && in_isLd) begin
                a = int'(in_result % 4);
                sz = int'(in_ldSize);
                if (sz == 3 || (sz == 1 && a % 2 != 0) || (sz == 2 && a != 0)) e_err = 1;
                else begin
                    m_busy = 1; m_rd = in_rd; m_off = a; m_size = sz; m_uns = in_ldUnsigned; m_wait = 0;
                end
            end else if (in_valid && in_isWb && in_rd != 0) begin
                e_wb = 1; e_addr = in_rd; e_data = in_result;
            end
        end else if (mem_rvalid) begin
            m_busy = 0;
            if (m_rd != 0) begin
                e_wb = 1; e_addr = m_rd; e_data = fmt(mem_rdata, m_off, m_size, m_uns);
            end
        end else begin
            m_wait++;
            if (m_wait == LT) begin
                m_busy = 0; e_err = 1;
            end
        end
        if (e_wb) e_cnt = e_cnt + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 0; mem_rvalid = 0; in_isLd = 0; in_isWb = 0;
        reset = 0;
        @(posedge clk);
        #2;
        reset = 1;
        model_clear();
    endtask

    task automatic issue(input logic [3:0] rd, input logic [31:0] a, input logic [1:0] sz, input logic u);
        in_valid = 1; in_isLd = 1; in_isWb = 1; in_rd = rd; in_result = a; in_ldSize = sz; in_ldUnsigned = u;
        tick();
        in_valid = 0; in_isLd = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if ({isWb, ld_err, pend_valid, pend_rd, writeaddress, writeData, wb_count, in_ready} !== {3'b000, 4'd0, 4'd0, 32'd0, 32'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_outputs: isWb=%0b err=%0b pv=%0b prd=%0d wa=%0d wd=%h cnt=%0d rdy=%0b want zeros rdy=1",
                     isWb, ld_err, pend_valid, pend_rd, writeaddress, writeData, wb_count, in_ready);
        end
        tick();
        n_chk++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: in_ready=%0b want 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        in_valid = 1; in_isLd = 0; in_isWb = 1; in_rd = 3; in_result = 32'h12345678;
        tick();
        in_rd = 4; in_result = 32'hCAFEF00D;
        n_chk++;
        if ({isWb, writeaddress, writeData} !== {1'b1, 4'd3, 32'h12345678}) begin
            n_fail++; $display("FAIL b2b_first: isWb=%0b wa=%0d wd=%h want 1/3/12345678", isWb, writeaddress, writeData);
        end
        tick();
        in_valid = 0;
        n_chk++;
        if ({isWb, writeaddress, writeData, wb_count} !== {1'b1, 4'd4, 32'hCAFEF00D, 32'd2}) begin
            n_fail++; $display("FAIL b2b_second: isWb=%0b wa=%0d wd=%h cnt=%0d want 1/4/cafef00d/2", isWb, writeaddress, writeData, wb_count);
        end
        tick();
        n_chk++;
        if ({isWb, writeaddress, writeData, wb_count} !== {1'b0, 4'd4, 32'hCAFEF00D, 32'd2}) begin
            n_fail++; $display("FAIL b2b_hold: isWb=%0b wa=%0d wd=%h cnt=%0d want 0/4/cafef00d/2", isWb, writeaddress, writeData, wb_count);
        end
    endtask

    task automatic test_byte_load();
        do_reset();
        issue(4'd5, 32'h101, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if ({in_ready, pend_valid, pend_rd, isWb} !== {1'b0, 1'b1, 4'd5, 1'b0}) begin
                n_fail++; $display("FAIL byte_wait%0d: rdy=%0b pv=%0b prd=%0d isWb=%0b want 0/1/5/0", i, in_ready, pend_valid, pend_rd, isWb);
            end
            if (i < 2) tick();
        end
        mem_rvalid = 1; mem_rdata = 32'h0000_80FF;
        tick();
        mem_rvalid = 0;
        n_chk++;
        if ({isWb, writeaddress, writeData, in_ready, pend_valid, wb_count} !== {1'b1, 4'd5, 32'hFFFFFF80, 2'b10, 32'd1}) begin
            n_fail++; $display("FAIL byte_signed: isWb=%0b wa=%0d wd=%h rdy=%0b pv=%0b cnt=%0d want 1/5/ffffff80/1/0/1",
                               isWb, writeaddress, writeData, in_ready, pend_valid, wb_count);
        end
        issue(4'd5, 32'h101, 2'b00, 1'b1);
        tick();
        tick();
        mem_rvalid = 1;
        tick();
        mem_rvalid = 0;
        n_chk++;
        if ({isWb, writeData, wb_count} !== {1'b1, 32'h00000080, 32'd2}) begin
            n_fail++; $display("FAIL byte_unsigned: isWb=%0b wd=%h cnt=%0d want 1/00000080/2", isWb, writeData, wb_count);
        end
    endtask

    task automatic test_half_word();
        do_reset();
        issue(4'd6, 32'h2, 2'b01, 1'b0);
        mem_rvalid = 1; mem_rdata = 32'h8001_7FFF;
        tick();
        mem_rvalid = 0;
        n_chk++;
        if ({isWb, writeaddress, writeData} !== {1'b1, 4'd6, 32'hFFFF8001}) begin
            n_fail++; $display("FAIL half_signed: isWb=%0b wa=%0d wd=%h want 1/6/ffff8001", isWb, writeaddress, writeData);
        end
        issue(4'd7, 32'h6, 2'b10, 1'b0);
        n_chk++;
        if ({ld_err, isWb, in_ready, pend_valid} !== 4'b1010) begin
            n_fail++; $display("FAIL word_misaligned: err=%0b isWb=%0b rdy=%0b pv=%0b want 1/0/1/0", ld_err, isWb, in_ready, pend_valid);
        end
        tick();
        n_chk++;
        if ({ld_err, in_ready, wb_count} !== {2'b01, 32'd1}) begin
            n_fail++; $display("FAIL err_pulse: err=%0b rdy=%0b cnt=%0d want 0/1/1", ld_err, in_ready, wb_count);
        end
    endtask

    task automatic test_idle_rvalid();
        do_reset();
        mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
        tick();
        tick();
        mem_rvalid = 0;
        n_chk++;
        if ({isWb, ld_err, wb_count, in_ready} !== {2'b00, 32'd0, 1'b1}) begin
            n_fail++; $display("FAIL idle_rvalid: isWb=%0b err=%0b cnt=%0d rdy=%0b want 0/0/0/1", isWb, ld_err, wb_count, in_ready);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        issue(4'd8, 32'h40, 2'b10, 1'b0);
        for (int i = 1; i < LT; i++) begin
            tick();
            n_chk++;
            if ({in_ready, ld_err} !== 2'b00) begin
                n_fail++; $display("FAIL timeout_early%0d: rdy=%0b err=%0b want 0/0", i, in_ready, ld_err);
            end
        end
        tick();
        n_chk++;
        if ({ld_err, isWb, in_ready, wb_count} !== {3'b101, 32'd0}) begin
            n_fail++; $display("FAIL timeout_err: err=%0b isWb=%0b rdy=%0b cnt=%0d want 1/0/1/0", ld_err, isWb, in_ready, wb_count);
        end
        issue(4'd8, 32'h40, 2'b10, 1'b0);
        for (int i = 1; i < LT; i++) tick();
        mem_rvalid = 1; mem_rdata = 32'h1357_9BDF;
        tick();
        mem_rvalid = 0;
        n_chk++;
        if ({isWb, ld_err, writeaddress, writeData} !== {2'b10, 4'd8, 32'h13579BDF}) begin
            n_fail++; $display("FAIL timeout_last_rvalid: isWb=%0b err=%0b wa=%0d wd=%h want 1/0/8/13579bdf", isWb, ld_err, writeaddress, writeData);
        end
    endtask

    task automatic test_rd0();
        do_reset();
        issue(4'd0, 32'h0, 2'b10, 1'b0);
        mem_rvalid = 1; mem_rdata = 32'h5555AAAA;
        tick();
        mem_rvalid = 0;
        n_chk++;
        if ({isWb, wb_count, in_ready} !== {1'b0, 32'd0, 1'b1}) begin
            n_fail++; $display("FAIL load_rd0: isWb=%0b cnt=%0d rdy=%0b want 0/0/1", isWb, wb_count, in_ready);
        end
        in_valid = 1; in_isLd = 0; in_isWb = 1; in_rd = 0; in_result = 32'h77;
        tick();
        in_valid = 0;
        n_chk++;
        if ({isWb, wb_count} !== {1'b0, 32'd0}) begin
            n_fail++; $display("FAIL alu_rd0: isWb=%0b cnt=%0d want 0/0", isWb, wb_count);
        end
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        in_valid = 1; in_isLd = 0; in_isWb = 1; in_rd = 2; in_result = 32'h99;
        tick();
        issue(4'd9, 32'h0, 2'b10, 1'b0);
        reset = 0;
        #1;
        n_chk++;
        if ({pend_valid, pend_rd, in_ready, wb_count} !== {1'b0, 4'd0, 1'b1, 32'd0}) begin
            n_fail++; $display("FAIL async_reset: pv=%0b prd=%0d rdy=%0b cnt=%0d want 0/0/1/0", pend_valid, pend_rd, in_ready, wb_count);
        end
        @(posedge clk);
        #2;
        reset = 1;
        model_clear();
        mem_rvalid = 1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_rvalid = 0;
        n_chk++;
        if ({isWb, ld_err, pend_valid, pend_rd, writeaddress, writeData, wb_count, in_ready} !== {3'b000, 4'd0, 4'd0, 32'd0, 32'd0, 1'b1}) begin
            n_fail++; $display("FAIL reset_drop_load: isWb=%0b err=%0b pv=%0b wa=%0d wd=%h cnt=%0d rdy=%0b want zeros rdy=1",
                               isWb, ld_err, pend_valid, writeaddress, writeData, wb_count, in_ready);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_isLd = ($urandom_range(0, 2) == 0);
            in_isWb = 1'($urandom_range(0, 1));
            in_rd = 4'($urandom_range(0, 15));
            in_result = $urandom;
            in_ldSize = 2'($urandom_range(0, 3));
            in_ldUnsigned = 1'($urandom_range(0, 1));
            mem_rvalid = i < 400 ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            mem_rdata = $urandom;
            tick();
            n_chk++;
            if ({isWb, ld_err, in_ready, pend_valid} !== {e_wb, e_err, !m_busy, m_busy}) begin
                n_fail++; $display("FAIL rand_ctrl@%0d: wb/err/rdy/pv=%b%b%b%b want %b%b%b%b", i, isWb, ld_err, in_ready, pend_valid,
                                   e_wb, e_err, !m_busy, m_busy);
            end
            n_chk++;
            if ({writeaddress, writeData, wb_count} !== {e_addr, e_data, e_cnt}) begin
                n_fail++; $display("FAIL rand_data@%0d: wa=%0d wd=%h cnt=%0d want %0d/%h/%0d", i, writeaddress, writeData, wb_count,
                                   e_addr, e_data, e_cnt);
            end
            if (m_busy) begin
                n_chk++;
                if (pend_rd !== m_rd) begin n_fail++; $display("FAIL rand_pend_rd@%0d: %0d want %0d", i, pend_rd, m_rd); end
            end
        end
        in_valid = 0; mem_rvalid = 0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_byte_load();
        test_half_word();
        test_idle_rvalid();
        test_timeout();
        test_rd0();
        test_reset_in_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter LOAD_TIMEOUT, default 16, meaning the maximum number of cycles spent in WAIT_LD before the pending load is abandoned.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream result valid.
REQ-005 in_ready  output  1  stage can accept; in_valid&&in_ready is a transfer.
REQ-006 in_rd  input  4  destination register.
REQ-007 in_result  input  32  ALU result, or byte address for loads.
REQ-008 in_isWb  input  1  instruction writes a register.
REQ-009 in_isLd  input  1  instruction is a load; the result comes from memory.
REQ-010 in_ldSize  input  2  load size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-011 in_ldUnsigned  input  1  zero-extend, not sign-extend, byte/half loads.
REQ-012 mem_rvalid  input  1  load data valid, one-cycle pulse.
REQ-013 mem_rdata  input  32  raw aligned memory word.
REQ-014 isWb  output  1  register-file write enable, one-cycle pulse.
REQ-015 writeaddress  output  4  register-file write address.
REQ-016 writeData  output  32  register-file write data.
REQ-017 pend_valid  output  1  a load is outstanding, for decode hazard stall.
REQ-018 pend_rd  output  4  destination register of the outstanding load.
REQ-019 ld_err  output  1  misaligned, reserved-size or timed-out load, one-cycle pulse.
REQ-020 wb_count  output  32  count of register-file writes issued.

Function
REQ-021 States SHALL be IDLE and WAIT_LD; in_ready SHALL equal 1 in IDLE and 0 in WAIT_LD.
REQ-022 In IDLE, a transfer with in_isLd=0, in_isWb=1, in_rd!=0 SHALL drive isWb=1, writeaddress=in_rd, writeData=in_result in the next cycle, giving 1-cycle latency and 1 transfer per cycle.
REQ-023 A non-load transfer with in_isWb=0 or in_rd=0 SHALL produce no write.
REQ-024 A load transfer SHALL be misaligned when (half && addr[0]) or (word && addr[1:0]!=0), and size 11 SHALL be treated the same way.
REQ-025 A misaligned load SHALL pulse ld_err the next cycle, produce no write and remain in IDLE.
REQ-026 A valid load transfer SHALL capture in_rd, addr[1:0], size and unsigned, clear the wait counter and enter WAIT_LD the next cycle.
REQ-027 In WAIT_LD, pend_valid SHALL be 1 and pend_rd the captured rd; otherwise pend_valid SHALL be 0.
REQ-028 In WAIT_LD, mem_rvalid=1 SHALL return the block to IDLE and, when the captured rd!=0, drive isWb=1 with the formatted data the next cycle.
REQ-029 Byte formatting SHALL select mem_rdata[8*off+7:8*off]; half formatting SHALL select mem_rdata[15:0] for off=00 and [31:16] for off=10.
REQ-030 Byte and half data SHALL be sign-extended unless unsigned, and word data SHALL pass unchanged.
REQ-031 The wait counter SHALL increment each WAIT_LD cycle without rvalid.
REQ-032 When the counter equals LOAD_TIMEOUT-1 and rvalid=0, the block SHALL return to IDLE with a next-cycle ld_err pulse and no write.
REQ-033 rvalid in the timeout cycle SHALL take precedence, with a normal write and no error.
REQ-034 mem_rvalid in IDLE SHALL be ignored: no write and no error.
REQ-035 When isWb=0, writeaddress and writeData SHALL hold their last values.
REQ-036 All outputs SHALL be registered, so they are stable before the register file's negedge write.
REQ-037 wb_count SHALL increment by 1 for every isWb pulse and wrap from 0xFFFFFFFF to 0.

Reset
REQ-038 reset=0 SHALL asynchronously force state IDLE and set isWb, ld_err, pend_valid, pend_rd, writeaddress, writeData, wb_count and the wait counter to 0.
REQ-039 A load outstanding at reset SHALL be dropped, and an rvalid after reset release SHALL be ignored.
REQ-040 in_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-041 Transfers of rd=3/0x12345678 then rd=4/0xCAFEF00D on consecutive cycles -> isWb pulses on 2 consecutive cycles with matching address/data, and wb_count=2.
REQ-042 Byte load at addr 0x101, signed, rvalid 3 cycles later with rdata 0x0000_80FF -> in_ready low 3 cycles, pend_valid=1 with pend_rd=rd, write data 0xFFFFFF80; repeated unsigned -> 0x00000080.
REQ-043 Half load at addr 0x2 with rdata 0x8001_7FFF -> 0xFFFF8001; word load at addr 0x6 -> ld_err pulse, no write, in_ready stays 1.
REQ-044 Load with no rvalid -> ld_err after exactly LOAD_TIMEOUT WAIT_LD cycles and no write; rvalid in the final cycle -> write and no ld_err.
REQ-045 Load with rd=0 and rvalid -> no write; ALU transfer with rd=0 -> no write; wb_count unchanged in both cases.
REQ-046 reset asserted while in WAIT_LD, then rvalid after release -> outputs all 0, no write, in_ready=1.
